tawas_regfile_mt: RTL and testbench

TAWAS_REGFILE_MT -- requirements
Module: tawas_regfile_mt

---
 rtl/tawas_regfile_mt_if.sv | 82 ++++++++
 rtl/tawas_regfile_mt.sv | 154 +++++++++++++++
 tb/tb_tawas_regfile_mt.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tawas_regfile_mt_if.sv
// Register file bus bundle: read selects/data, write ports,
// remote load scoreboard and status outputs.
interface tawas_regfile_mt_if #(
    parameter int THREADS = 4,
    parameter int REGS    = 8,
    parameter int DW      = 32,
    parameter int PCW     = 24
);
    localparam int TW = $clog2(THREADS);
    localparam int RW = $clog2(REGS);

    logic [TW-1:0]      SLICE;
    logic               PC_STORE;
    logic [PCW-1:0]     PC;
    logic [PCW-1:0]     PC_RTN;

    logic               RF_IMM_VLD;
    logic [RW-1:0]      RF_IMM_SEL;
    logic [DW-1:0]      RF_IMM;

    logic [RW-1:0]      AU_RA_SEL;
    logic [RW-1:0]      AU_RB_SEL;
    logic [RW-1:0]      LS_PTR_SEL;
    logic [RW-1:0]      LS_STORE_SEL;
    logic [DW-1:0]      AU_RA;
    logic [DW-1:0]      AU_RB;
    logic [DW-1:0]      LS_PTR;
    logic [DW-1:0]      LS_STORE;

    logic               AU_RC_VLD;
    logic [RW-1:0]      AU_RC_SEL;
    logic [DW-1:0]      AU_RC;

    logic               LS_PTR_UPD_VLD;
    logic [RW-1:0]      LS_PTR_UPD_SEL;
    logic [DW-1:0]      LS_PTR_UPD;

    logic               LS_LOAD_VLD;
    logic [RW-1:0]      LS_LOAD_SEL;
    logic [DW-1:0]      LS_LOAD;

    logic               RACCOON_REQ_VLD;
    logic [TW-1:0]      RACCOON_REQ_THR;
    logic [RW-1:0]      RACCOON_REQ_SEL;

    logic               RACCOON_LOAD_VLD;
    logic [TW-1:0]      RACCOON_LOAD_THR;
    logic [RW-1:0]      RACCOON_LOAD_SEL;
    logic [DW-1:0]      RACCOON_LOAD;

    logic [3:0]         HAZARD;
    logic [THREADS-1:0] PEND_ANY;
    logic [7:0]         COLL_CNT;

    modport master (
        output SLICE, PC_STORE, PC,
        output RF_IMM_VLD, RF_IMM_SEL, RF_IMM,
        output AU_RA_SEL, AU_RB_SEL, LS_PTR_SEL, LS_STORE_SEL,
        output AU_RC_VLD, AU_RC_SEL, AU_RC,
        output LS_PTR_UPD_VLD, LS_PTR_UPD_SEL, LS_PTR_UPD,
        output LS_LOAD_VLD, LS_LOAD_SEL, LS_LOAD,
        output RACCOON_REQ_VLD, RACCOON_REQ_THR, RACCOON_REQ_SEL,
        output RACCOON_LOAD_VLD, RACCOON_LOAD_THR,
        output RACCOON_LOAD_SEL, RACCOON_LOAD,
        input  PC_RTN, AU_RA, AU_RB, LS_PTR, LS_STORE,
        input  HAZARD, PEND_ANY, COLL_CNT
    );

    modport slave (
        input  SLICE, PC_STORE, PC,
        input  RF_IMM_VLD, RF_IMM_SEL, RF_IMM,
        input  AU_RA_SEL, AU_RB_SEL, LS_PTR_SEL, LS_STORE_SEL,
        input  AU_RC_VLD, AU_RC_SEL, AU_RC,
        input  LS_PTR_UPD_VLD, LS_PTR_UPD_SEL, LS_PTR_UPD,
        input  LS_LOAD_VLD, LS_LOAD_SEL, LS_LOAD,
        input  RACCOON_REQ_VLD, RACCOON_REQ_THR, RACCOON_REQ_SEL,
        input  RACCOON_LOAD_VLD, RACCOON_LOAD_THR,
        input  RACCOON_LOAD_SEL, RACCOON_LOAD,
        output PC_RTN, AU_RA, AU_RB, LS_PTR, LS_STORE,
        output HAZARD, PEND_ANY, COLL_CNT
    );
endinterface

// File: rtl/tawas_regfile_mt.sv
// Multi-thread register file: one bank per pipeline slot thread,
// prioritised write ports, remote-load scoreboard, collision counter.
module tawas_regfile_mt #(
    parameter int THREADS = 4,
    parameter int REGS    = 8,
    parameter int DW      = 32,
    parameter int PCW     = 24,
    parameter int RTN_REG = 6
) (
    input logic              CLK,
    input logic              RST,
    tawas_regfile_mt_if.slave bus
);
    localparam int TW = $clog2(THREADS);
    localparam int RW = $clog2(REGS);
    localparam int NP = 6;

    logic [DW-1:0]      rf_q   [THREADS][REGS];
    logic [DW-1:0]      rf_d   [THREADS][REGS];
    logic [REGS-1:0]    pend_q [THREADS];
    logic [REGS-1:0]    pend_d [THREADS];
    logic [7:0]         coll_q;
    logic [7:0]         coll_d;

    logic [TW-1:0]      thr_rd;
    logic [TW-1:0]      thr_rc;
    logic [TW-1:0]      thr_upd;
    logic [TW-1:0]      thr_ld;

    logic               wv [NP];
    logic [TW-1:0]      wt [NP];
    logic [RW-1:0]      wr [NP];
    logic [DW-1:0]      wd [NP];
    logic               coll;
    logic [THREADS-1:0] pend_any;

    assign thr_rd  = bus.SLICE - TW'(1);
    assign thr_rc  = bus.SLICE + TW'(1);
    assign thr_upd = bus.SLICE + TW'(2);
    assign thr_ld  = bus.SLICE;

    // Port table ordered lowest to highest priority.
    always_comb begin
        wv[0] = bus.RACCOON_LOAD_VLD;
        wt[0] = bus.RACCOON_LOAD_THR;
        wr[0] = bus.RACCOON_LOAD_SEL;
        wd[0] = bus.RACCOON_LOAD;
        wv[1] = bus.PC_STORE;
        wt[1] = thr_rd;
        wr[1] = RW'(RTN_REG);
        wd[1] = DW'(bus.PC);
        wv[2] = bus.RF_IMM_VLD;
        wt[2] = thr_rd;
        wr[2] = bus.RF_IMM_SEL;
        wd[2] = bus.RF_IMM;
        wv[3] = bus.AU_RC_VLD;
        wt[3] = thr_rc;
        wr[3] = bus.AU_RC_SEL;
        wd[3] = bus.AU_RC;
        wv[4] = bus.LS_PTR_UPD_VLD;
        wt[4] = thr_upd;
        wr[4] = bus.LS_PTR_UPD_SEL;
        wd[4] = bus.LS_PTR_UPD;
        wv[5] = bus.LS_LOAD_VLD;
        wt[5] = thr_ld;
        wr[5] = bus.LS_LOAD_SEL;
        wd[5] = bus.LS_LOAD;
    end

    always_comb begin
        rf_d = rf_q;
        for (int p = 0; p < NP; p++) begin
            if (wv[p]) begin
                rf_d[wt[p]][wr[p]] = wd[p];
            end
        end
    end

    always_comb begin
        coll = 1'b0;
        for (int i = 0; i < NP; i++) begin
            for (int j = i + 1; j < NP; j++) begin
                if (wv[i] && wv[j] &&
                    wt[i] == wt[j] &&
                    wr[i] == wr[j]) begin
                    coll = 1'b1;
                end
            end
        end
        coll_d = coll_q;
        if (coll && coll_q != 8'hFF) begin
            coll_d = coll_q + 8'd1;
        end
    end

    // A request issued in the same cycle as a return must stay pending.
    always_comb begin
        pend_d = pend_q;
        if (bus.RACCOON_LOAD_VLD) begin
            pend_d[bus.RACCOON_LOAD_THR][bus.RACCOON_LOAD_SEL] = 1'b0;
        end
        if (bus.RACCOON_REQ_VLD) begin
            pend_d[bus.RACCOON_REQ_THR][bus.RACCOON_REQ_SEL] = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int t = 0; t < THREADS; t++) begin
                pend_q[t] <= '0;
                for (int r = 0; r < REGS; r++) begin
                    rf_q[t][r] <= '0;
                end
            end
            coll_q <= '0;
        end else begin
            rf_q   <= rf_d;
            pend_q <= pend_d;
            coll_q <= coll_d;
        end
    end

    always_comb begin
        pend_any = '0;
        for (int t = 0; t < THREADS; t++) begin
            pend_any[t] = |pend_q[t];
        end
    end

    // Outputs are forced low while reset is held.
    always_comb begin
        bus.AU_RA     = '0;
        bus.AU_RB     = '0;
        bus.LS_PTR    = '0;
        bus.LS_STORE  = '0;
        bus.PC_RTN    = '0;
        bus.HAZARD    = '0;
        bus.PEND_ANY  = '0;
        bus.COLL_CNT  = '0;
        if (!RST) begin
            bus.AU_RA     = rf_q[thr_rd][bus.AU_RA_SEL];
            bus.AU_RB     = rf_q[thr_rd][bus.AU_RB_SEL];
            bus.LS_PTR    = rf_q[thr_rd][bus.LS_PTR_SEL];
            bus.LS_STORE  = rf_q[thr_rd][bus.LS_STORE_SEL];
            bus.PC_RTN    = rf_q[thr_rd][RW'(RTN_REG)][PCW-1:0];
            bus.HAZARD[0] = pend_q[thr_rd][bus.AU_RA_SEL];
            bus.HAZARD[1] = pend_q[thr_rd][bus.AU_RB_SEL];
            bus.HAZARD[2] = pend_q[thr_rd][bus.LS_PTR_SEL];
            bus.HAZARD[3] = pend_q[thr_rd][bus.LS_STORE_SEL];
            bus.PEND_ANY  = pend_any;
            bus.COLL_CNT  = coll_q;
        end
    end
endmodule

// File: tb/tb_tawas_regfile_mt.sv
// Directed bench for tawas_regfile_mt with default parameters.
// Expected values are hand-derived from the thread mapping rules.
module tb_tawas_regfile_mt;
    logic CLK;
    logic RST;
    int   n_eval;
    int   n_fail;

    tawas_regfile_mt_if bus ();

    tawas_regfile_mt dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        bus.PC_STORE         = 1'b0;
        bus.PC               = '0;
        bus.RF_IMM_VLD       = 1'b0;
        bus.RF_IMM_SEL       = '0;
        bus.RF_IMM           = '0;
        bus.AU_RA_SEL        = '0;
        bus.AU_RB_SEL        = '0;
        bus.LS_PTR_SEL       = '0;
        bus.LS_STORE_SEL     = '0;
        bus.AU_RC_VLD        = 1'b0;
        bus.AU_RC_SEL        = '0;
        bus.AU_RC            = '0;
        bus.LS_PTR_UPD_VLD   = 1'b0;
        bus.LS_PTR_UPD_SEL   = '0;
        bus.LS_PTR_UPD       = '0;
        bus.LS_LOAD_VLD      = 1'b0;
        bus.LS_LOAD_SEL      = '0;
        bus.LS_LOAD          = '0;
        bus.RACCOON_REQ_VLD  = 1'b0;
        bus.RACCOON_REQ_THR  = '0;
        bus.RACCOON_REQ_SEL  = '0;
        bus.RACCOON_LOAD_VLD = 1'b0;
        bus.RACCOON_LOAD_THR = '0;
        bus.RACCOON_LOAD_SEL = '0;
        bus.RACCOON_LOAD     = '0;
    endtask

    // Read thread = SLICE-1, so select SLICE = thr+1.
    task automatic rd(input int thr, input int sel);
        bus.SLICE     = 2'((thr + 1) % 4);
        bus.AU_RA_SEL = 3'(sel);
        #1;
    endtask

    initial begin
        n_eval = 0;
        n_fail = 0;
        RST = 1'b1;
        bus.SLICE = '0;
        clr();
        step();
        step();
        chk("rst_au_ra", bus.AU_RA, 0);
        chk("rst_coll", 32'(bus.COLL_CNT), 0);
        chk("rst_pend", 32'(bus.PEND_ANY), 0);
        chk("rst_hazard", 32'(bus.HAZARD), 0);
        RST = 1'b0;

        bus.SLICE      = 2'd1;
        bus.RF_IMM_VLD = 1'b1;
        bus.RF_IMM_SEL = 3'd3;
        bus.RF_IMM     = 32'hDEADBEEF;
        step();
        clr();
        rd(0, 3); chk("imm_t0_r3", bus.AU_RA, 32'hDEADBEEF);
        rd(1, 3); chk("imm_t1_r3", bus.AU_RA, 0);
        rd(2, 3); chk("imm_t2_r3", bus.AU_RA, 0);
        rd(3, 3); chk("imm_t3_r3", bus.AU_RA, 0);

        bus.SLICE          = 2'd0;
        bus.AU_RC_VLD      = 1'b1;
        bus.AU_RC_SEL      = 3'd2;
        bus.AU_RC          = 32'h100;
        bus.LS_PTR_UPD_VLD = 1'b1;
        bus.LS_PTR_UPD_SEL = 3'd2;
        bus.LS_PTR_UPD     = 32'h200;
        bus.LS_LOAD_VLD    = 1'b1;
        bus.LS_LOAD_SEL    = 3'd2;
        bus.LS_LOAD        = 32'h300;
        step();
        clr();
        rd(1, 2); chk("rc_t1_r2", bus.AU_RA, 32'h100);
        rd(2, 2); chk("upd_t2_r2", bus.AU_RA, 32'h200);
        rd(0, 2); chk("ld_t0_r2", bus.AU_RA, 32'h300);
        chk("nocoll", 32'(bus.COLL_CNT), 0);

        bus.SLICE      = 2'd2;
        bus.RF_IMM_VLD = 1'b1;
        bus.RF_IMM_SEL = 3'd6;
        bus.RF_IMM     = 32'hAA;
        bus.PC_STORE   = 1'b1;
        bus.PC         = 24'h123456;
        step();
        clr();
        rd(1, 6); chk("imm_over_pc", bus.AU_RA, 32'hAA);
        chk("pc_rtn_aa", 32'(bus.PC_RTN), 32'hAA);
        chk("coll_1", 32'(bus.COLL_CNT), 1);

        bus.SLICE    = 2'd2;
        bus.PC_STORE = 1'b1;
        bus.PC       = 24'hABCDEF;
        step();
        clr();
        rd(1, 6); chk("pc_store", bus.AU_RA, 32'h00ABCDEF);
        chk("pc_rtn", 32'(bus.PC_RTN), 32'hABCDEF);
        chk("coll_still1", 32'(bus.COLL_CNT), 1);

        bus.SLICE            = 2'd0;
        bus.LS_LOAD_VLD      = 1'b1;
        bus.LS_LOAD_SEL      = 3'd0;
        bus.LS_LOAD          = 32'h77;
        bus.RACCOON_LOAD_VLD = 1'b1;
        bus.RACCOON_LOAD_THR = 2'd0;
        bus.RACCOON_LOAD_SEL = 3'd0;
        bus.RACCOON_LOAD     = 32'h88;
        step();
        clr();
        rd(0, 0); chk("ld_over_raccoon", bus.AU_RA, 32'h77);
        chk("coll_2", 32'(bus.COLL_CNT), 2);

        bus.RACCOON_REQ_VLD = 1'b1;
        bus.RACCOON_REQ_THR = 2'd2;
        bus.RACCOON_REQ_SEL = 3'd1;
        step();
        clr();
        chk("pend_t2", 32'(bus.PEND_ANY), 32'b0100);
        bus.SLICE     = 2'd3;
        bus.AU_RB_SEL = 3'd1;
        #1;
        chk("hazard_rb", 32'(bus.HAZARD), 32'b0010);
        bus.LS_STORE_SEL = 3'd1;
        #1;
        chk("hazard_rb_st", 32'(bus.HAZARD), 32'b1010);
        clr();

        bus.SLICE     = 2'd1;
        bus.AU_RC_VLD = 1'b1;
        bus.AU_RC_SEL = 3'd1;
        bus.AU_RC     = 32'h99;
        step();
        clr();
        rd(2, 1); chk("rc_pending_reg", bus.AU_RA, 32'h99);
        chk("pend_kept", 32'(bus.PEND_ANY), 32'b0100);

        bus.RACCOON_LOAD_VLD = 1'b1;
        bus.RACCOON_LOAD_THR = 2'd2;
        bus.RACCOON_LOAD_SEL = 3'd1;
        bus.RACCOON_LOAD     = 32'h55;
        step();
        clr();
        chk("pend_clr", 32'(bus.PEND_ANY), 0);
        bus.SLICE      = 2'd3;
        bus.AU_RB_SEL  = 3'd1;
        bus.LS_PTR_SEL = 3'd1;
        #1;
        chk("au_rb_load", bus.AU_RB, 32'h55);
        chk("ls_ptr_load", bus.LS_PTR, 32'h55);
        chk("hazard_clr", 32'(bus.HAZARD), 0);
        clr();

        bus.RACCOON_REQ_VLD  = 1'b1;
        bus.RACCOON_REQ_THR  = 2'd0;
        bus.RACCOON_REQ_SEL  = 3'd7;
        bus.RACCOON_LOAD_VLD = 1'b1;
        bus.RACCOON_LOAD_THR = 2'd0;
        bus.RACCOON_LOAD_SEL = 3'd7;
        bus.RACCOON_LOAD     = 32'h5A;
        step();
        clr();
        chk("set_wins", 32'(bus.PEND_ANY), 32'b0001);
        rd(0, 7); chk("raccoon_data", bus.AU_RA, 32'h5A);
        chk("coll_2b", 32'(bus.COLL_CNT), 2);

        bus.RACCOON_LOAD_VLD = 1'b1;
        bus.RACCOON_LOAD_THR = 2'd0;
        bus.RACCOON_LOAD_SEL = 3'd7;
        bus.RACCOON_LOAD     = 32'h5B;
        step();
        clr();
        chk("pend_t0_clr", 32'(bus.PEND_ANY), 0);

        bus.SLICE      = 2'd2;
        bus.RF_IMM_VLD = 1'b1;
        bus.RF_IMM_SEL = 3'd6;
        bus.RF_IMM     = 32'h1234;
        bus.PC_STORE   = 1'b1;
        bus.PC         = 24'h00FFFF;
        for (int i = 0; i < 300; i++) begin
            step();
        end
        clr();
        chk("coll_sat", 32'(bus.COLL_CNT), 255);

        bus.RACCOON_REQ_VLD = 1'b1;
        bus.RACCOON_REQ_THR = 2'd1;
        bus.RACCOON_REQ_SEL = 3'd2;
        step();
        clr();
        chk("pend_t1", 32'(bus.PEND_ANY), 32'b0010);
        rd(1, 6); chk("pre_rst_data", bus.AU_RA, 32'h1234);
        chk("pre_rst_pc", 32'(bus.PC_RTN), 32'h1234);
        bus.AU_RA_SEL = 3'd2;
        #1;
        chk("pre_rst_haz", 32'(bus.HAZARD), 32'b0001);

        #1;
        RST = 1'b1;
        #1;
        chk("mid_rst_coll", 32'(bus.COLL_CNT), 0);
        chk("mid_rst_pend", 32'(bus.PEND_ANY), 0);
        chk("mid_rst_haz", 32'(bus.HAZARD), 0);
        chk("mid_rst_pc", 32'(bus.PC_RTN), 0);
        bus.AU_RA_SEL = 3'd6;
        #1;
        chk("mid_rst_ra", bus.AU_RA, 0);

        step();
        RST            = 1'b0;
        bus.SLICE      = 2'd1;
        bus.RF_IMM_VLD = 1'b1;
        bus.RF_IMM_SEL = 3'd5;
        bus.RF_IMM     = 32'hCAFE;
        step();
        clr();
        rd(0, 5); chk("post_rst_wr", bus.AU_RA, 32'hCAFE);
        rd(0, 3); chk("post_rst_clr", bus.AU_RA, 0);
        rd(1, 6); chk("post_rst_t1", bus.AU_RA, 0);
        chk("post_rst_coll", 32'(bus.COLL_CNT), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_eval, n_fail);
        $finish;
    end
endmodule
